// File: rtl/difftest_step_sched.sv
// difftest_step_sched: batches per-cycle difftest commit steps into single-outstanding multi-step check requests
// Ports: clock/reset (async, active-high); step_in steps committed this cycle; max_cycles limit (0 = none);
//        req_valid/req_ready/req_nstep check request handshake; rsp_valid/rsp_fail checker result pulse;
//        init_pulse one-cycle checker init; hold accumulator near full (gate the DUT); n_cycles cycles since reset;
//        fail/exceeded sticky flags; stop = registered fail | exceeded.
// Optional: define DIFFTEST_SCHED_PERF_EN to add perf_reqs, perf_hold and perf_wait counters.
module difftest_step_sched #(
  parameter int STEP_WIDTH   = 8,
  parameter int ACC_WIDTH    = 16,
  parameter int BATCH_THRESH = 32,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STEP_WIDTH-1:0] step_in,
  input  logic [63:0]           max_cycles,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ACC_WIDTH-1:0]  req_nstep,
  input  logic                  rsp_valid,
  input  logic                  rsp_fail,
  output logic                  init_pulse,
  output logic                  hold,
  output logic [63:0]           n_cycles,
`ifdef DIFFTEST_SCHED_PERF_EN
  output logic [63:0]           perf_reqs,
  output logic [63:0]           perf_hold,
  output logic [63:0]           perf_wait,
`endif
  output logic                  fail,
  output logic                  exceeded,
  output logic                  stop
);
  localparam int TW = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
  localparam logic [ACC_WIDTH:0] THRESH = (ACC_WIDTH + 1)'(BATCH_THRESH);
  // Highest accumulator value that still absorbs one full-scale step without wrapping.
  localparam logic [ACC_WIDTH-1:0] HOLD_LVL = ~ACC_WIDTH'((1 << STEP_WIDTH) - 1);
  typedef enum logic [2:0] {INIT, RUN, ISSUE, WAIT, STOP} state_t;
  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, nstep_q, nstep_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [63:0]            cyc_q, cyc_d;
  logic                   req_valid_q, req_valid_d, init_q, init_d;
  logic                   fail_q, fail_d, exceeded_q, exceeded_d, stop_q, stop_d;
  logic [ACC_WIDTH:0]     sum;
  logic                   trig, hit, live;
  always_comb begin
    cyc_d       = cyc_q + 64'd1;
    // Compare against the incremented count so exceeded rises together with n_cycles == max_cycles.
    hit         = (max_cycles != 64'd0) && (cyc_d >= max_cycles);
    sum         = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - STEP_WIDTH){1'b0}}, step_in};
    trig        = (sum >= THRESH) || ((timer_q == FLUSH_LAST) && (acc_q != '0));
    live        = state_q != STOP;
    acc_d       = live ? sum[ACC_WIDTH-1:0] : acc_q;
    timer_d     = timer_q;
    nstep_d     = nstep_q;
    req_valid_d = req_valid_q;
    state_d     = state_q;
    init_d      = state_q == INIT;
    fail_d      = fail_q;
    exceeded_d  = exceeded_q | hit;
    stop_d      = fail_q | exceeded_q;
    case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        timer_d = ((acc_q != '0) && (step_in == '0)) ? timer_q + TW'(1) : '0;
        if (trig) begin
          nstep_d     = sum[ACC_WIDTH-1:0];
          acc_d       = '0;
          timer_d     = '0;
          req_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        req_valid_d = ~req_ready;
        state_d     = req_ready ? WAIT : ISSUE;
      end
      WAIT: begin
        fail_d  = fail_q | (rsp_valid & rsp_fail);
        state_d = rsp_valid ? (rsp_fail ? STOP : RUN) : WAIT;
      end
      default: ;
    endcase
    // The cycle limit overrides everything, abandoning any in-flight request.
    if (hit) begin
      state_d     = STOP;
      req_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= INIT;
      acc_q       <= '0;
      nstep_q     <= '0;
      timer_q     <= '0;
      cyc_q       <= '0;
      req_valid_q <= 1'b0;
      init_q      <= 1'b0;
      fail_q      <= 1'b0;
      exceeded_q  <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      nstep_q     <= nstep_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      req_valid_q <= req_valid_d;
      init_q      <= init_d;
      fail_q      <= fail_d;
      exceeded_q  <= exceeded_d;
      stop_q      <= stop_d;
    end
  assign req_valid  = req_valid_q;
  assign req_nstep  = nstep_q;
  assign init_pulse = init_q;
  assign hold       = acc_q >= HOLD_LVL;
  assign n_cycles   = cyc_q;
  assign fail       = fail_q;
  assign exceeded   = exceeded_q;
  assign stop       = stop_q;
`ifdef DIFFTEST_SCHED_PERF_EN
  logic [63:0] perf_reqs_q, perf_reqs_d, perf_hold_q, perf_hold_d, perf_wait_q, perf_wait_d;
  always_comb begin
    perf_reqs_d = perf_reqs_q + {63'd0, (state_q == ISSUE) & req_ready};
    perf_hold_d = perf_hold_q + {63'd0, live & hold};
    perf_wait_d = perf_wait_q + {63'd0, (state_q == ISSUE) | (state_q == WAIT)};
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      perf_reqs_q <= '0;
      perf_hold_q <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_reqs_q <= perf_reqs_d;
      perf_hold_q <= perf_hold_d;
      perf_wait_q <= perf_wait_d;
    end
  assign perf_reqs = perf_reqs_q;
  assign perf_hold = perf_hold_q;
  assign perf_wait = perf_wait_q;
`endif
endmodule

// File: tb/tb_difftest_step_sched.sv
// tb_difftest_step_sched: self-checking bench for difftest_step_sched
module tb_difftest_step_sched;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  step_in = '0;
  logic [63:0] max_cycles = '0;
  logic        req_valid, req_ready = 1'b0;
  logic [15:0] req_nstep;
  logic        rsp_valid = 1'b0, rsp_fail = 1'b0;
  logic        init_pulse, hold, fail, exceeded, stop;
  logic [63:0] n_cycles;
  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic [7:0]  step;
    logic        rdy, rv, rf;
    logic [15:0] push;
    logic        ev;
    logic [15:0] en;
    logic        ef, es;
  } vec_t;
  vec_t tbl[12];
  always #5 clock = ~clock;
  difftest_step_sched dut (
    .clock(clock), .reset(reset), .step_in(step_in), .max_cycles(max_cycles),
    .req_valid(req_valid), .req_ready(req_ready), .req_nstep(req_nstep),
    .rsp_valid(rsp_valid), .rsp_fail(rsp_fail), .init_pulse(init_pulse), .hold(hold),
    .n_cycles(n_cycles), .fail(fail), .exceeded(exceeded), .stop(stop)
  );
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [7:0] s, input logic rdy, input logic rv, input logic rf);
    step_in   = s;
    req_ready = rdy;
    rsp_valid = rv;
    rsp_fail  = rf;
  endtask
  task automatic check_zero(input string name);
    check(name, {req_valid, req_nstep, init_pulse, hold, n_cycles, fail, exceeded, stop}, 128'd0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_outputs");
    reset = 1'b0;
  endtask
  // Every accepted request is compared with the oldest expected batch size.
  always @(negedge clock)
    if (!reset && req_valid && req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake: got nstep %0d expected no request", req_nstep);
      end else check("handshake_nstep", req_nstep, exp_q.pop_front());
    end
  initial begin
    int rise, bad;
    tbl[0]  = '{8'd8,  1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[1]  = '{8'd8,  1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[2]  = '{8'd8,  1'b0, 1'b1, 1'b1, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[3]  = '{8'd8,  1'b0, 1'b0, 1'b0, 16'd32, 1'b1, 16'd32, 1'b0, 1'b0};
    tbl[4]  = '{8'd0,  1'b0, 1'b0, 1'b0, 16'd0,  1'b1, 16'd32, 1'b0, 1'b0};
    tbl[5]  = '{8'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[6]  = '{8'd0,  1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[7]  = '{8'd0,  1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[8]  = '{8'd0,  1'b0, 1'b1, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[9]  = '{8'd40, 1'b0, 1'b0, 1'b0, 16'd40, 1'b1, 16'd40, 1'b0, 1'b0};
    tbl[10] = '{8'd0,  1'b1, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    tbl[11] = '{8'd0,  1'b0, 1'b1, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 1'b0};
    #2;
    do_reset;
    check("n_cycles_after_release", n_cycles, 64'd0);
    tick;
    check("init_pulse_first", init_pulse, 1'b1);
    check("n_cycles_first", n_cycles, 64'd1);
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].step, tbl[i].rdy, tbl[i].rv, tbl[i].rf);
      if (tbl[i].push != 16'd0) exp_q.push_back(tbl[i].push);
      tick;
      check($sformatf("vec%0d_valid", i), req_valid, tbl[i].ev);
      if (tbl[i].ev) check($sformatf("vec%0d_nstep", i), req_nstep, tbl[i].en);
      check($sformatf("vec%0d_fail", i), fail, tbl[i].ef);
      check($sformatf("vec%0d_stop", i), stop, tbl[i].es);
    end
    check("init_pulse_once", init_pulse, 1'b0);
    drive(3, 0, 0, 0);
    exp_q.push_back(16'd3);
    tick;
    drive(0, 0, 0, 0);
    rise = 0;
    for (int i = 1; i <= 80 && rise == 0; i++) begin
      tick;
      if (req_valid) rise = i;
    end
    check("flush_idle_cycles", rise, 64);
    check("flush_nstep", req_nstep, 16'd3);
    drive(0, 1, 0, 0);
    tick;
    check("flush_valid_drop", req_valid, 1'b0);
    drive(0, 0, 1, 0);
    tick;
    for (int i = 0; i < 7; i++) begin
      drive(5, 0, 0, 0);
      if (i == 6) exp_q.push_back(16'd35);
      tick;
    end
    check("bp_issue_valid", req_valid, 1'b1);
    check("bp_issue_nstep", req_nstep, 16'd35);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(5, 0, 0, 0);
      tick;
      if (!req_valid || req_nstep !== 16'd35) bad++;
    end
    check("bp_held_cycles_bad", bad, 0);
    drive(0, 1, 0, 0);
    tick;
    check("bp_valid_drop", req_valid, 1'b0);
    drive(0, 0, 1, 0);
    tick;
    check("bp_back_to_run", req_valid, 1'b0);
    drive(0, 0, 0, 0);
    exp_q.push_back(16'd50);
    tick;
    check("bp_b2b_valid", req_valid, 1'b1);
    check("bp_b2b_nstep", req_nstep, 16'd50);
    drive(0, 1, 0, 0);
    tick;
    drive(0, 0, 1, 1);
    tick;
    check("mm_fail", fail, 1'b1);
    check("mm_stop_not_yet", stop, 1'b0);
    drive(0, 0, 0, 0);
    tick;
    check("mm_stop", stop, 1'b1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive(40, 1, 0, 0);
      tick;
      if (req_valid) bad++;
    end
    check("mm_no_req_after_stop", bad, 0);
    check("mm_no_exceeded", exceeded, 1'b0);
    check("queue_empty_1", exp_q.size(), 0);
    do_reset;
    max_cycles = 64'd100;
    bad = 0;
    for (int c = 0; c < 101; c++) begin
      drive(32, c < 90, 1, 0);
      if (c == 1) exp_q.push_back(16'd64);
      else if (c >= 4 && c <= 88 && c % 3 == 1) exp_q.push_back(16'd96);
      tick;
      if (n_cycles !== 64'(c + 1)) bad++;
      if (c + 1 < 100 && exceeded) bad++;
      if (c + 1 == 99) begin
        check("max_outstanding_valid", req_valid, 1'b1);
        check("max_outstanding_nstep", req_nstep, 16'd96);
      end
      if (c + 1 == 100) begin
        check("max_exceeded", exceeded, 1'b1);
        check("max_valid_drop", req_valid, 1'b0);
        check("max_stop_not_yet", stop, 1'b0);
      end
      if (c + 1 == 101) check("max_stop", stop, 1'b1);
    end
    check("max_cycle_count_bad", bad, 0);
    check("max_no_fail", fail, 1'b0);
    check("queue_empty_2", exp_q.size(), 0);
    max_cycles = 64'd0;
    do_reset;
    drive(0, 0, 0, 0);
    tick;
    drive(255, 0, 0, 0);
    tick;
    check("full_issue_valid", req_valid, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      drive(255, 0, 0, 0);
      tick;
      if (k == 255) check("hold_below", hold, 1'b0);
      if (k == 256) check("hold_at_level", hold, 1'b1);
    end
    check("pre_reset_valid", req_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset_outputs");
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("restart_n_cycles", n_cycles, 64'd0);
    tick;
    check("restart_init_pulse", init_pulse, 1'b1);
    check("restart_n1", n_cycles, 64'd1);
    tick;
    check("restart_init_drop", init_pulse, 1'b0);
    check("restart_n2", n_cycles, 64'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
